// File: rtl/magma_dec.sv
// Iterative GOST R 34.12-2015 "Magma" block decryptor: one Feistel round per clock, 32 rounds per block.
// Define MAGMA_DEC_KEY_LATCH_EN to capture the key on accept; otherwise the key port must stay stable during RUN.
module magma_dec (
    input  logic         clk,
    input  logic         reset_,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  data_in,
    input  logic [255:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  data_out
);

    // S-box pi_j lives in SBOX[64*j +: 64], entry v at nibble v.
    localparam logic [511:0] SBOX = {
        64'h2BC96AF43850DE71, 64'h73AD0B4FC19652E8,
        64'h0E34187BAC296FD5, 64'hC24BE390D618A5F7,
        64'hB9E35A076F4D128C, 64'h069C471EDAF2853B,
        64'hF0DB74E1C5A93286, 64'h1F307D8E9B5A264C
    };

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state, state_nxt;
    logic [31:0]  a1, a0;
    logic [4:0]   r;
    logic [255:0] key_use;
    logic [2:0]   slot;
    logic [31:0]  k_r;
    logic [31:0]  g_out;
    logic         accept;
    logic         last_round;

    function automatic logic [31:0] sbox_layer(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int j = 0; j < 8; j++) begin
            y[4*j +: 4] = SBOX[64*j + 4*int'(x[4*j +: 4]) +: 4];
        end
        return y;
    endfunction

    function automatic logic [31:0] round_g(input logic [31:0] k, input logic [31:0] x);
        logic [31:0] s;
        s = sbox_layer(x + k);
        return {s[20:0], s[31:21]};
    endfunction

`ifdef MAGMA_DEC_KEY_LATCH_EN
    logic [255:0] key_q;

    always_ff @(posedge clk) begin
        if (accept) begin
            key_q <= key;
        end
    end

    assign key_use = key_q;
`else
    assign key_use = key;
`endif

    // Rounds 0..7 walk K1..K8 (slots 7..0); later rounds walk K8..K1 (slots 0..7).
    assign slot       = (r[4:3] == 2'b00) ? ~r[2:0] : r[2:0];
    assign k_r        = key_use[{slot, 5'd0} +: 32];
    assign g_out      = round_g(k_r, a0);
    assign accept     = in_valid && in_ready;
    assign last_round = (state == RUN) && (r == 5'd31);

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state     <= IDLE;
            r         <= '0;
            out_valid <= 1'b0;
            data_out  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                r <= '0;
            end else if (state == RUN && !last_round) begin
                r <= r + 5'd1;
            end
            if (last_round) begin
                out_valid <= 1'b1;
                data_out  <= {g_out ^ a1, a0};
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a1 <= data_in[63:32];
            a0 <= data_in[31:0];
        end else if (state == RUN) begin
            a1 <= a0;
            a0 <= g_out ^ a1;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (r == 5'd31) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
